// File: rtl/icache_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned IDX_W_DEF = 6;
    localparam int unsigned TAG_W_DEF = 32 - IDX_W_DEF - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TAG   = 2'd1,
        S_FILL  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/icache_ram.sv
// Tag+data storage: one synchronous read port, one write port, no reset.
module icache_ram #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned W     = 56
) (
    input  logic             clk_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i
);

    logic [W-1:0] mem_q [2**IDX_W];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between fetch and the memory controller.
// state | meaning: IDLE wait for fetch | TAG compare | FILL wait mct | DRAIN finish killed fill
module icache
    import icache_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_e_i,
    input  logic [31:0] if_a_i,
    output logic        if_ok_o,
    output logic [31:0] if_n_o,
    input  logic        kill_i,
    input  logic        flush_i,
    output logic        mct_e_o,
    output logic [31:0] mct_a_o,
    input  logic [31:0] mct_n_i,
    input  logic        mct_ok_i
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;
    localparam int unsigned LINES = 2**IDX_W;

    state_e             state_q, state_d;
    logic [31:0]        req_a_q, req_a_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic               if_ok_q, if_ok_d;
    logic [31:0]        if_n_q, if_n_d;
    logic               mct_e_q, mct_e_d;
    logic [31:0]        mct_a_q, mct_a_d;

    logic               ram_re, ram_we;
    logic [TAG_W+31:0]  ram_rdata;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               unused_ok;

    assign req_idx   = req_a_q[IDX_W+1:2];
    assign req_tag   = req_a_q[31:IDX_W+2];
    assign hit       = valid_q[req_idx] && (ram_rdata[TAG_W+31:32] == req_tag);
    assign unused_ok = ^if_a_i[1:0];

    icache_ram #(
        .IDX_W (IDX_W),
        .W     (TAG_W + 32)
    ) u_ram (
        .clk_i   (clk_i),
        .re_i    (ram_re),
        .raddr_i (if_a_i[IDX_W+1:2]),
        .rdata_o (ram_rdata),
        .we_i    (ram_we),
        .waddr_i (req_idx),
        .wdata_i ({req_tag, mct_n_i})
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            req_a_q <= '0;
            valid_q <= '0;
            if_ok_q <= 1'b0;
            if_n_q  <= '0;
            mct_e_q <= 1'b0;
            mct_a_q <= '0;
        end else begin
            state_q <= state_d;
            req_a_q <= req_a_d;
            valid_q <= valid_d;
            if_ok_q <= if_ok_d;
            if_n_q  <= if_n_d;
            mct_e_q <= mct_e_d;
            mct_a_q <= mct_a_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_a_d = req_a_q;
        valid_d = valid_q;
        if_ok_d = 1'b0;
        if_n_d  = if_n_q;
        mct_e_d = mct_e_q;
        mct_a_d = mct_a_q;
        ram_re  = 1'b0;
        ram_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_e_i && !kill_i && !if_ok_q) begin
                    req_a_d = {if_a_i[31:2], 2'b00};
                    ram_re  = 1'b1;
                    state_d = S_TAG;
                end
            end
            S_TAG: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    if_ok_d = 1'b1;
                    if_n_d  = ram_rdata[31:0];
                    state_d = S_IDLE;
                end else begin
                    mct_e_d = 1'b1;
                    mct_a_d = req_a_q;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mct_ok_i) begin
                    ram_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    mct_e_d          = 1'b0;
                    state_d          = S_IDLE;
                    if (!kill_i) begin
                        if_ok_d = 1'b1;
                        if_n_d  = mct_n_i;
                    end
                end else if (kill_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The memory transfer cannot be aborted; keep the data, drop the response.
                if (mct_ok_i) begin
                    ram_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    mct_e_d          = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            valid_d = '0;
        end
    end

    assign if_ok_o = if_ok_q;
    assign if_n_o  = if_n_q;
    assign mct_e_o = mct_e_q;
    assign mct_a_o = mct_a_q;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: hits, misses, conflicts, kill, flush, reset.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        if_e;
    logic [31:0] if_a;
    logic        if_ok;
    logic [31:0] if_n;
    logic        kill;
    logic        flush;
    logic        mct_e;
    logic [31:0] mct_a;
    logic [31:0] mct_n;
    logic        mct_ok;

    int checks = 0;
    int errors = 0;

    logic        f_ok;
    logic [31:0] f_n;
    logic        f_mct;
    logic [31:0] f_mct_a;
    int          f_lat;

    icache dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .if_e_i   (if_e),
        .if_a_i   (if_a),
        .if_ok_o  (if_ok),
        .if_n_o   (if_n),
        .kill_i   (kill),
        .flush_i  (flush),
        .mct_e_o  (mct_e),
        .mct_a_o  (mct_a),
        .mct_n_i  (mct_n),
        .mct_ok_i (mct_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one fetch and acts as the memory: mct_ok on the third cycle mct_e is seen.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] mem_data);
        int waits;
        f_ok = 1'b0; f_n = '0; f_mct = 1'b0; f_mct_a = '0; f_lat = -1;
        waits = 0;
        if_e = 1'b1;
        if_a = addr;
        for (int i = 0; i < 30; i++) begin
            tick();
            mct_ok = 1'b0;
            if (if_ok) begin
                f_ok = 1'b1;
                f_n = if_n;
                f_lat = i;
                break;
            end
            if (mct_e) begin
                f_mct = 1'b1;
                f_mct_a = mct_a;
                waits++;
                if (waits == 3) begin
                    mct_ok = 1'b1;
                    mct_n = mct_data_or(mem_data);
                end
            end
        end
        if_e = 1'b0;
        mct_ok = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] mct_data_or(input logic [31:0] d);
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b0; if_e = 1'b1; if_a = 32'h10; kill = 1'b0; flush = 1'b0;
        mct_n = '0; mct_ok = 1'b0;
        tick(); tick();
        checks++;
        if ({if_ok, if_n, mct_e, mct_a} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs: got if_ok=%b if_n=%h mct_e=%b mct_a=%h, want all zero",
                     if_ok, if_n, mct_e, mct_a);
        end
        if_e = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_first_miss();
        do_fetch(32'h10, 32'h00500093);
        checks++;
        if (f_mct !== 1'b1 || f_mct_a !== 32'h10) begin
            errors++;
            $display("FAIL miss_mct_a: got mct=%b a=%h, want mct=1 a=00000010", f_mct, f_mct_a);
        end
        checks++;
        if (f_ok !== 1'b1 || f_n !== 32'h00500093) begin
            errors++;
            $display("FAIL miss_data: got ok=%b n=%h, want ok=1 n=00500093", f_ok, f_n);
        end
        checks++;
        if (if_ok !== 1'b0) begin
            errors++;
            $display("FAIL miss_ok_pulse: got if_ok=%b one cycle later, want 0", if_ok);
        end
    endtask

    task automatic test_hit();
        do_fetch(32'h10, 32'hDEADBEEF);
        checks++;
        if (f_mct !== 1'b0 || f_ok !== 1'b1 || f_n !== 32'h00500093 || f_lat != 1) begin
            errors++;
            $display("FAIL hit_0x10: got mct=%b ok=%b n=%h lat=%0d, want mct=0 ok=1 n=00500093 lat=1",
                     f_mct, f_ok, f_n, f_lat);
        end
        // Low address bits are ignored.
        do_fetch(32'h13, 32'hDEADBEEF);
        checks++;
        if (f_mct !== 1'b0 || f_n !== 32'h00500093) begin
            errors++;
            $display("FAIL hit_unaligned: got mct=%b n=%h, want mct=0 n=00500093", f_mct, f_n);
        end
    endtask

    task automatic test_conflict();
        do_fetch(32'h110, 32'hAAAA0001);
        checks++;
        if (f_mct !== 1'b1 || f_mct_a !== 32'h110 || f_n !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL conflict_fill: got mct=%b a=%h n=%h, want mct=1 a=00000110 n=aaaa0001",
                     f_mct, f_mct_a, f_n);
        end
        do_fetch(32'h10, 32'h00500093);
        checks++;
        if (f_mct !== 1'b1 || f_n !== 32'h00500093) begin
            errors++;
            $display("FAIL conflict_refetch: got mct=%b n=%h, want mct=1 n=00500093", f_mct, f_n);
        end
        do_fetch(32'h14, 32'h00A00113);
        checks++;
        if (f_mct !== 1'b1 || f_n !== 32'h00A00113) begin
            errors++;
            $display("FAIL fill_0x14: got mct=%b n=%h, want mct=1 n=00a00113", f_mct, f_n);
        end
    endtask

    task automatic test_kill();
        logic seen_ok;
        // kill while in FILL: transfer finishes in DRAIN, no response
        if_e = 1'b1; if_a = 32'h20;
        tick(); tick();
        kill = 1'b1; if_e = 1'b0;
        tick();
        kill = 1'b0;
        checks++;
        if (mct_e !== 1'b1) begin
            errors++;
            $display("FAIL drain_hold: got mct_e=%b, want 1", mct_e);
        end
        tick(); tick();
        mct_ok = 1'b1; mct_n = 32'h12345678;
        tick();
        mct_ok = 1'b0;
        seen_ok = if_ok;
        tick();
        seen_ok = seen_ok | if_ok;
        checks++;
        if (seen_ok !== 1'b0 || mct_e !== 1'b0) begin
            errors++;
            $display("FAIL drain_no_ok: got if_ok=%b mct_e=%b, want 0 0", seen_ok, mct_e);
        end
        do_fetch(32'h20, 32'hDEADBEEF);
        checks++;
        if (f_mct !== 1'b0 || f_n !== 32'h12345678) begin
            errors++;
            $display("FAIL drain_hit: got mct=%b n=%h, want mct=0 n=12345678", f_mct, f_n);
        end
        // kill and mct_ok on the same edge
        if_e = 1'b1; if_a = 32'h30;
        tick(); tick();
        if_e = 1'b0;
        tick();
        kill = 1'b1; mct_ok = 1'b1; mct_n = 32'h0BADF00D;
        tick();
        kill = 1'b0; mct_ok = 1'b0;
        checks++;
        if (if_ok !== 1'b0 || mct_e !== 1'b0) begin
            errors++;
            $display("FAIL kill_with_ok: got if_ok=%b mct_e=%b, want 0 0", if_ok, mct_e);
        end
        tick();
        do_fetch(32'h30, 32'hDEADBEEF);
        checks++;
        if (f_mct !== 1'b0 || f_n !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL kill_with_ok_hit: got mct=%b n=%h, want mct=0 n=0badf00d", f_mct, f_n);
        end
        // kill in TAG: no memory request, no response
        if_e = 1'b1; if_a = 32'h40;
        tick();
        kill = 1'b1; if_e = 1'b0;
        tick();
        kill = 1'b0;
        checks++;
        if (if_ok !== 1'b0 || mct_e !== 1'b0) begin
            errors++;
            $display("FAIL kill_tag: got if_ok=%b mct_e=%b, want 0 0", if_ok, mct_e);
        end
        // kill in IDLE blocks the accept for that cycle only
        if_e = 1'b1; if_a = 32'h20; kill = 1'b1;
        tick();
        kill = 1'b0;
        tick();
        checks++;
        if (if_ok !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_block: got if_ok=%b, want 0", if_ok);
        end
        tick();
        if_e = 1'b0;
        checks++;
        if (if_ok !== 1'b1 || if_n !== 32'h12345678) begin
            errors++;
            $display("FAIL kill_idle_late_hit: got if_ok=%b n=%h, want 1 12345678", if_ok, if_n);
        end
        tick();
        // mct_ok while idle must not disturb anything
        mct_ok = 1'b1; mct_n = 32'hFFFFFFFF;
        tick();
        mct_ok = 1'b0;
        do_fetch(32'h20, 32'hDEADBEEF);
        checks++;
        if (f_mct !== 1'b0 || f_n !== 32'h12345678) begin
            errors++;
            $display("FAIL stray_mct_ok: got mct=%b n=%h, want mct=0 n=12345678", f_mct, f_n);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        do_fetch(32'h10, 32'h00500093);
        checks++;
        if (f_mct !== 1'b1 || f_n !== 32'h00500093) begin
            errors++;
            $display("FAIL flush_miss_0x10: got mct=%b n=%h, want mct=1 n=00500093", f_mct, f_n);
        end
        do_fetch(32'h14, 32'h00A00113);
        checks++;
        if (f_mct !== 1'b1 || f_n !== 32'h00A00113) begin
            errors++;
            $display("FAIL flush_miss_0x14: got mct=%b n=%h, want mct=1 n=00a00113", f_mct, f_n);
        end
        // flush coincident with fill completion
        if_e = 1'b1; if_a = 32'h50;
        tick(); tick();
        mct_ok = 1'b1; flush = 1'b1; mct_n = 32'h55667788;
        tick();
        mct_ok = 1'b0; flush = 1'b0; if_e = 1'b0;
        checks++;
        if (if_ok !== 1'b1 || if_n !== 32'h55667788) begin
            errors++;
            $display("FAIL flush_fill_ok: got if_ok=%b n=%h, want 1 55667788", if_ok, if_n);
        end
        tick();
        do_fetch(32'h50, 32'h55667788);
        checks++;
        if (f_mct !== 1'b1) begin
            errors++;
            $display("FAIL flush_fill_invalid: got mct=%b, want 1", f_mct);
        end
    endtask

    task automatic test_reset_mid_fill();
        if_e = 1'b1; if_a = 32'h60;
        tick(); tick();
        rst = 1'b0; if_e = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (mct_e !== 1'b0 || if_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_fill: got mct_e=%b if_ok=%b, want 0 0", mct_e, if_ok);
        end
        tick();
        do_fetch(32'h10, 32'h00500093);
        checks++;
        if (f_mct !== 1'b1 || f_n !== 32'h00500093) begin
            errors++;
            $display("FAIL reset_miss_0x10: got mct=%b n=%h, want mct=1 n=00500093", f_mct, f_n);
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hit();
        test_conflict();
        test_kill();
        test_flush();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
